// File: rtl/strng_pkg.sv
// strng_pkg: FSM state encoding and fixed timing constants shared by the
// strng_ctrl slice.
package strng_pkg;

  localparam int RING_RST_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RING_RST = 3'd1,
    ST_WARMUP   = 3'd2,
    ST_COLLECT  = 3'd3,
    ST_OUTPUT   = 3'd4
  } state_t;

endpackage

// File: rtl/strng_sync.sv
// strng_sync: W-bit two-flop synchronizer with asynchronous clear, used to
// bring the free-running ring stage outputs into the clk domain.
module strng_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/strng_ctrl.sv
// strng_ctrl: runs a self-timed ring (reset, warm-up, sampling) and packs
// XOR-reduced ring samples into words. STRNG_RCT_EN adds a repetition-count test.
module strng_ctrl
  import strng_pkg::*;
#(
  parameter int LEN        = 8,
  parameter int WORD_W     = 32,
  parameter int WARMUP     = 64,
  parameter int SAMPLE_DIV = 4,
  parameter int RCT_LIMIT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              ring_rst_n,
  input  logic [LEN-1:0]    ring_s,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              busy,
  output logic              err,
  output logic [2:0]        state_dbg
);

  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam logic [15:0]      RST_LAST  = 16'(RING_RST_CYCLES - 1);
  localparam logic [15:0]      WARM_LAST = 16'(WARMUP - 1);
  localparam logic [7:0]       DIV_LAST  = 8'(SAMPLE_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);

  state_t            state_q, state_d;
  logic [15:0]       cyc_cnt;
  logic [7:0]        div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [LEN-1:0]    ring_sync;
  logic              raw_bit;
  logic              sample_tick;
  logic              word_done;
  logic              rct_fail;

  strng_sync #(.W(LEN)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ring_s),
    .q   (ring_sync)
  );

  assign raw_bit     = ^ring_sync;
  assign sample_tick = (state_q == ST_COLLECT) && (div_cnt == DIV_LAST);
  assign word_done   = sample_tick && (bit_cnt == BIT_LAST);

  // Handshake: a word transfers on any edge where rnd_valid and rnd_ready are
  // both high; once raised, rnd_valid and rnd_data hold until that edge.
  assign rnd_valid  = (state_q == ST_OUTPUT);
  assign ring_rst_n = (state_q == ST_WARMUP) || (state_q == ST_COLLECT) ||
                      (state_q == ST_OUTPUT);
  assign busy       = (state_q != ST_IDLE);
  assign state_dbg  = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (en) state_d = ST_RING_RST;
      ST_RING_RST: if (!en) state_d = ST_IDLE;
                   else if (cyc_cnt == RST_LAST) state_d = ST_WARMUP;
      ST_WARMUP:   if (!en) state_d = ST_IDLE;
                   else if (cyc_cnt == WARM_LAST) state_d = ST_COLLECT;
      ST_COLLECT:  if (!en) state_d = ST_IDLE;
                   else if (rct_fail) state_d = ST_RING_RST;
                   else if (word_done) state_d = ST_OUTPUT;
      ST_OUTPUT:   if (rnd_ready) state_d = en ? ST_COLLECT : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // cyc_cnt times RING_RST and WARMUP; div/bit counters restart on every COLLECT entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt  <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      rnd_data <= '0;
    end else begin
      if (state_d != state_q) cyc_cnt <= '0;
      else if (state_q == ST_RING_RST || state_q == ST_WARMUP) cyc_cnt <= cyc_cnt + 16'd1;

      if (state_d == ST_COLLECT && state_q != ST_COLLECT) begin
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (state_q == ST_COLLECT) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          bit_cnt <= bit_cnt + 1'b1;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end

      if (sample_tick) rnd_data <= {rnd_data[WORD_W-2:0], raw_bit};
    end
  end

`ifdef STRNG_RCT_EN
  logic [7:0] rct_cnt;
  logic       last_bit;

  // The run length carries across words while the ring keeps running.
  assign rct_fail = sample_tick && (raw_bit == last_bit) &&
                    (rct_cnt == 8'(RCT_LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rct_cnt  <= '0;
      last_bit <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (state_q == ST_IDLE || state_q == ST_RING_RST) begin
        rct_cnt  <= '0;
        last_bit <= 1'b0;
      end else if (sample_tick) begin
        rct_cnt  <= (rct_cnt != 8'd0 && raw_bit == last_bit) ? rct_cnt + 8'd1 : 8'd1;
        last_bit <= raw_bit;
      end

      if (state_q == ST_IDLE && en) err <= 1'b0;
      else if (rct_fail)           err <= 1'b1;
    end
  end
`else
  assign rct_fail = 1'b0;
  assign err      = 1'b0;
`endif

endmodule
